// File: rtl/fsm_transition_resolver_if.sv
// Transition descriptor bundle plus resolver status outputs.
// FSM_TRANSITION_TRACE_EN adds prev_state and trans_count.
interface fsm_transition_resolver_if #(
    parameter int INPUTS  = 8,
    parameter int STATES  = 16,
    parameter int DWELL_W = 16
);
    localparam int PRWIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int STWIDTH = (STATES > 1) ? $clog2(STATES) : 1;

    logic [INPUTS-1:0]         ine;
    logic [INPUTS*PRWIDTH-1:0] prio;
    logic [INPUTS*STWIDTH-1:0] next_states;
    logic                      hold;
    logic [STWIDTH-1:0]        state;
    logic                      fired;
    logic [PRWIDTH-1:0]        fired_idx;
    logic                      changed;
    logic [DWELL_W-1:0]        dwell;
    logic                      illegal;
`ifdef FSM_TRANSITION_TRACE_EN
    logic [STWIDTH-1:0]        prev_state;
    logic [15:0]               trans_count;
`endif

    modport master (
        output ine, prio, next_states, hold,
        input  state, fired, fired_idx, changed, dwell, illegal
`ifdef FSM_TRANSITION_TRACE_EN
        , input prev_state, trans_count
`endif
    );

    modport slave (
        input  ine, prio, next_states, hold,
        output state, fired, fired_idx, changed, dwell, illegal
`ifdef FSM_TRANSITION_TRACE_EN
        , output prev_state, trans_count
`endif
    );
endinterface

// File: rtl/fsm_transition_resolver.sv
// Arbitrates enabled transitions (lowest prio, then lowest index) and owns the FSM state register.
// Optional trace outputs (prev_state, trans_count) are built when FSM_TRANSITION_TRACE_EN is defined.
module fsm_transition_resolver #(
    parameter int INPUTS      = 8,
    parameter int STATES      = 16,
    parameter int RESET_STATE = 0,
    parameter int DWELL_W     = 16
) (
    input logic                   clk,
    input logic                   rst,
    fsm_transition_resolver_if.slave bus
);
    localparam int PRWIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int STWIDTH = (STATES > 1) ? $clog2(STATES) : 1;
    localparam logic [STWIDTH:0]   STATES_W = STATES[STWIDTH:0];
    localparam logic [STWIDTH-1:0] RESET_W  = RESET_STATE[STWIDTH-1:0];

    logic [STWIDTH-1:0] state_q;
    logic               fired_q;
    logic [PRWIDTH-1:0] fired_idx_q;
    logic               changed_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               illegal_q;

    logic               win_found;
    logic [PRWIDTH-1:0] win_idx;
    logic [PRWIDTH-1:0] win_prio;
    logic [STWIDTH-1:0] win_tgt;
    logic               any_illegal;
    logic               commit;
    logic               do_change;

    // Strict less-than keeps the earliest index on equal priority.
    always_comb begin
        win_found   = 1'b0;
        win_idx     = '0;
        win_prio    = '0;
        win_tgt     = '0;
        any_illegal = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (bus.ine[i]) begin
                if ({1'b0, bus.next_states[i*STWIDTH +: STWIDTH]} >= STATES_W) begin
                    any_illegal = 1'b1;
                end else if (!win_found || (bus.prio[i*PRWIDTH +: PRWIDTH] < win_prio)) begin
                    win_found = 1'b1;
                    win_idx   = PRWIDTH'(i);
                    win_prio  = bus.prio[i*PRWIDTH +: PRWIDTH];
                    win_tgt   = bus.next_states[i*STWIDTH +: STWIDTH];
                end
            end
        end
    end

    assign commit    = win_found && !bus.hold;
    assign do_change = commit && (win_tgt != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_W;
            fired_q     <= 1'b0;
            fired_idx_q <= '0;
            changed_q   <= 1'b0;
            dwell_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= illegal_q | any_illegal;
            fired_q   <= commit;
            changed_q <= do_change;
            if (commit) begin
                fired_idx_q <= win_idx;
            end
            if (do_change) begin
                state_q <= win_tgt;
                dwell_q <= '0;
            end else if (dwell_q != {DWELL_W{1'b1}}) begin
                dwell_q <= dwell_q + DWELL_W'(1);
            end
        end
    end

`ifdef FSM_TRANSITION_TRACE_EN
    logic [STWIDTH-1:0] prev_state_q;
    logic [15:0]        trans_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_q  <= '0;
            trans_count_q <= '0;
        end else if (do_change) begin
            prev_state_q <= state_q;
            if (trans_count_q != 16'hFFFF) begin
                trans_count_q <= trans_count_q + 16'd1;
            end
        end
    end

    assign bus.prev_state  = prev_state_q;
    assign bus.trans_count = trans_count_q;
`endif

    assign bus.state     = state_q;
    assign bus.fired     = fired_q;
    assign bus.fired_idx = fired_idx_q;
    assign bus.changed   = changed_q;
    assign bus.dwell     = dwell_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_fsm_transition_resolver.sv
// Directed bench: table vectors on a default resolver, hand sequences on a 12-state / 4-bit-dwell one.
module tb_fsm_transition_resolver;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ine;
    logic [23:0] prio;
    logic [31:0] next_states;
    logic        hold;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fsm_transition_resolver_if #(.INPUTS(8), .STATES(16), .DWELL_W(16)) bus_a ();
    fsm_transition_resolver_if #(.INPUTS(8), .STATES(12), .DWELL_W(4))  bus_b ();

    assign bus_a.ine = ine;  assign bus_a.prio = prio;
    assign bus_a.next_states = next_states;  assign bus_a.hold = hold;
    assign bus_b.ine = ine;  assign bus_b.prio = prio;
    assign bus_b.next_states = next_states;  assign bus_b.hold = hold;

    fsm_transition_resolver #(.INPUTS(8), .STATES(16), .RESET_STATE(0), .DWELL_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fsm_transition_resolver #(.INPUTS(8), .STATES(12), .RESET_STATE(0), .DWELL_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [7:0]  ine;
        logic [23:0] prio;
        logic [31:0] ns;
        logic        hold;
        logic [3:0]  st;
        logic        fired;
        logic [2:0]  idx;
        logic        changed;
        logic [15:0] dwell;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ine = '0; prio = '0; next_states = '0; hold = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset held two cycles with every input requesting a transition.
        ine = 8'hFF; next_states = 32'h7654_3210; prio = 24'o01234567;
        tick(); tick();
        check("reset_state", bus_a.state, 0);
        check("reset_fired", bus_a.fired, 0);
        check("reset_dwell", bus_a.dwell, 0);
        check("reset_illegal", bus_a.illegal, 0);
        check("reset_changed", bus_a.changed, 0);
        check("reset_b_state", bus_b.state, 0);
        rst = 1'b0;
        idle_inputs();
        tick();
        check("post_reset_state", bus_a.state, 0);
        check("post_reset_dwell", bus_a.dwell, 1);

        // Table vectors on dut_a, applied back to back after a fresh reset.
        vecs[0]  = '{8'h06, 24'o00000130, 32'h0000_0950, 1'b0, 4'd9, 1'b1, 3'd2, 1'b1, 16'd0};
        vecs[1]  = '{8'h48, 24'o02002000, 32'h0700_4000, 1'b0, 4'd4, 1'b1, 3'd3, 1'b1, 16'd0};
        vecs[2]  = '{8'h00, 24'o00000000, 32'h0000_0000, 1'b0, 4'd4, 1'b0, 3'd0, 1'b0, 16'd1};
        vecs[3]  = '{8'h00, 24'o00000000, 32'h0000_0000, 1'b0, 4'd4, 1'b0, 3'd0, 1'b0, 16'd2};
        vecs[4]  = '{8'h01, 24'o00000005, 32'h0000_0004, 1'b0, 4'd4, 1'b1, 3'd0, 1'b0, 16'd3};
        vecs[5]  = '{8'h80, 24'o00000000, 32'h1000_0000, 1'b1, 4'd4, 1'b0, 3'd0, 1'b0, 16'd4};
        vecs[6]  = '{8'h80, 24'o00000000, 32'h1000_0000, 1'b0, 4'd1, 1'b1, 3'd7, 1'b1, 16'd0};
        vecs[7]  = '{8'hFF, 24'o01234567, 32'h7654_3210, 1'b0, 4'd7, 1'b1, 3'd7, 1'b1, 16'd0};
        vecs[8]  = '{8'hFF, 24'o00000000, 32'h7654_3210, 1'b0, 4'd0, 1'b1, 3'd0, 1'b1, 16'd0};
        vecs[9]  = '{8'hFF, 24'o00000001, 32'h7654_3210, 1'b0, 4'd1, 1'b1, 3'd1, 1'b1, 16'd0};
        vecs[10] = '{8'h0C, 24'o00004500, 32'h0000_3200, 1'b0, 4'd3, 1'b1, 3'd3, 1'b1, 16'd0};

        do_reset();
        for (int v = 0; v < 11; v++) begin
            ine = vecs[v].ine; prio = vecs[v].prio;
            next_states = vecs[v].ns; hold = vecs[v].hold;
            tick();
            check($sformatf("vec%0d_state", v), bus_a.state, vecs[v].st);
            check($sformatf("vec%0d_fired", v), bus_a.fired, vecs[v].fired);
            check($sformatf("vec%0d_changed", v), bus_a.changed, vecs[v].changed);
            check($sformatf("vec%0d_dwell", v), bus_a.dwell, vecs[v].dwell);
            check($sformatf("vec%0d_illegal", v), bus_a.illegal, 0);
            if (vecs[v].fired) check($sformatf("vec%0d_idx", v), bus_a.fired_idx, vecs[v].idx);
        end

        // Hold freezes the state while dwell keeps counting; a later self-loop keeps dwell.
        do_reset();
        ine = 8'h02; next_states = 32'h0000_0090;
        tick();
        check("hold_pre_state", bus_a.state, 9);
        check("hold_pre_dwell", bus_a.dwell, 0);
        hold = 1'b1; next_states = 32'h0000_0020;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_fired", bus_a.fired, 0);
        end
        check("hold_state", bus_a.state, 9);
        check("hold_dwell", bus_a.dwell, 20);
        hold = 1'b0; next_states = 32'h0000_0090;
        tick();
        check("selfloop_fired", bus_a.fired, 1);
        check("selfloop_changed", bus_a.changed, 0);
        check("selfloop_dwell", bus_a.dwell, 21);
        check("selfloop_state", bus_a.state, 9);
        idle_inputs();
        tick();
        check("selfloop_fired_drop", bus_a.fired, 0);

        // Illegal target on the 12-state instance is skipped; a worse-priority legal one wins.
        do_reset();
        ine = 8'h21; prio = 24'o00700000; next_states = 32'h0030_000D;
        tick();
        check("illegal_b_state", bus_b.state, 3);
        check("illegal_b_idx", bus_b.fired_idx, 5);
        check("illegal_b_flag", bus_b.illegal, 1);
        check("illegal_a_state", bus_a.state, 13);
        check("illegal_a_idx", bus_a.fired_idx, 0);
        check("illegal_a_flag", bus_a.illegal, 0);
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("illegal_sticky", bus_b.illegal, 1);
        end
        check("illegal_idle_state", bus_b.state, 3);

        // Boundary: target 12 is illegal, 11 is the last legal state.
        do_reset();
        check("illegal_cleared", bus_b.illegal, 0);
        ine = 8'h03; prio = 24'o00000010; next_states = 32'h0000_00BC;
        tick();
        check("bound_state", bus_b.state, 11);
        check("bound_idx", bus_b.fired_idx, 1);
        check("bound_illegal", bus_b.illegal, 1);

        // Hold wins over enables but illegal detection stays live.
        do_reset();
        hold = 1'b1; ine = 8'h01; next_states = 32'h0000_000E;
        tick();
        check("hold_illegal_flag", bus_b.illegal, 1);
        check("hold_illegal_fired", bus_b.fired, 0);
        check("hold_illegal_state", bus_b.state, 0);

        // Dwell saturates at 15 on the 4-bit counter; reset overrides active inputs.
        do_reset();
        for (int c = 0; c < 20; c++) tick();
        check("sat_dwell_b", bus_b.dwell, 15);
        check("sat_dwell_a", bus_a.dwell, 20);
        ine = 8'h01; next_states = 32'h0000_0005; hold = 1'b0;
        tick();
        check("sat_change_state", bus_b.state, 5);
        check("sat_change_dwell", bus_b.dwell, 0);
        tick();
        tick();
        check("presat_dwell", bus_b.dwell, 2);
        rst = 1'b1; ine = 8'h01; next_states = 32'h0000_0007;
        tick();
        check("midrst_state", bus_b.state, 0);
        check("midrst_dwell", bus_b.dwell, 0);
        check("midrst_fired", bus_b.fired, 0);
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
